// File: rtl/dmem_pkg.sv
// Shared types and constants for the DMEM arbiter slice.
package dmem_pkg;

    localparam int DMEM_DEPTH = 256;
    localparam int WORD_W     = 32;

    localparam logic P_CORE = 1'b0;
    localparam logic P_LOAD = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // A word access is illegal when misaligned or at/after the end of DMEM.
    function automatic logic addr_bad(input logic [WORD_W-1:0] addr,
                                      input logic [WORD_W-1:0] limit);
        return (addr[1:0] != 2'b00) || (addr >= limit);
    endfunction

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating count of consecutive denied cycles for one requester;
// flags starvation once the count reaches MAX_WAIT.
module dmem_arb_wait_ctr #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_gnt,
    output logic o_starved
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_req || i_gnt) begin
            r_count <= '0;
        end else if (r_count != CW'(MAX_WAIT)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_starved = (r_count == CW'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port DMEM: round-robin with a
// port-1 burst lock, a starvation override and one-cycle registered responses.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH    = DMEM_DEPTH,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [WORD_W-1:0] p0_addr,
    input  logic [WORD_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [WORD_W-1:0] p0_rdata,
    output logic              p0_err,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [WORD_W-1:0] p1_addr,
    input  logic [WORD_W-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [WORD_W-1:0] p1_rdata,
    output logic              p1_err,

    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(DEPTH * 4);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_rr_last;

    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_starved0;
    logic       w_starved1;
    logic       w_err0;
    logic       w_err1;

    dmem_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (p0_req),
        .i_gnt     (w_gnt0),
        .o_starved (w_starved0)
    );

    dmem_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (p1_req),
        .i_gnt     (w_gnt1),
        .o_starved (w_starved1)
    );

    assign w_err0 = addr_bad(p0_addr, ADDR_LIMIT);
    assign w_err1 = addr_bad(p1_addr, ADDR_LIMIT);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;

        if (p0_req && w_starved0) begin
            w_gnt0 = 1'b1;
        end else if (p1_req && w_starved1) begin
            w_gnt1 = 1'b1;
        end else if ((r_state == LOCKED) && p1_req) begin
            w_gnt1 = 1'b1;
        end else if (p0_req && p1_req) begin
            if (r_rr_last == P_CORE) w_gnt1 = 1'b1;
            else                     w_gnt0 = 1'b1;
        end else if (p0_req) begin
            w_gnt0 = 1'b1;
        end else if (p1_req) begin
            w_gnt1 = 1'b1;
        end

        case (r_state)
            IDLE:    if (w_gnt1 && p1_lock) w_state_nxt = LOCKED;
            LOCKED:  if (!p1_lock || (w_gnt0 && w_starved0)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr_last <= P_LOAD;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt0)      r_rr_last <= P_CORE;
            else if (w_gnt1) r_rr_last <= P_LOAD;
        end
    end

    assign p0_gnt    = w_gnt0;
    assign p1_gnt    = w_gnt1;
    assign mem_addr  = w_gnt1 ? p1_addr  : p0_addr;
    assign mem_wdata = w_gnt1 ? p1_wdata : p0_wdata;
    // Gated by rst_n so a requester holding a write through reset cannot corrupt DMEM.
    assign mem_we    = rst_n & ((w_gnt0 & p0_we & ~w_err0) | (w_gnt1 & p1_we & ~w_err1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p0_err    <= 1'b0;
            p1_rvalid <= 1'b0;
            p1_rdata  <= '0;
            p1_err    <= 1'b0;
        end else begin
            p0_rvalid <= w_gnt0;
            p0_rdata  <= (w_gnt0 && !p0_we && !w_err0) ? mem_rdata : '0;
            p0_err    <= w_gnt0 & w_err0;
            p1_rvalid <= w_gnt1;
            p1_rdata  <= (w_gnt1 && !p1_we && !w_err1) ? mem_rdata : '0;
            p1_err    <= w_gnt1 & w_err1;
        end
    end

endmodule
